// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the multi-requester UART transmitter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    HOLD  = 3'd4
  } state_e;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  // Never returns less than 1 so derived vectors are never zero-width.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker; when locked, only the lock holder can win.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDW = clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] pointer_i,
  input  logic           lock_en_i,
  input  logic [IDW-1:0] lock_id_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] gnt_id_o
);

  localparam logic [IDW:0] N_W = (IDW+1)'(N);

  logic [IDW:0] sum;
  logic         found;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    sum      = '0;
    found    = 1'b0;
    if (lock_en_i) begin
      if (req_i[lock_id_i]) begin
        gnt_o[lock_id_i] = 1'b1;
        gnt_id_o         = lock_id_i;
      end
    end else begin
      // Scan from the pointer, wrapping modulo N, first valid wins.
      for (int k = 0; k < N; k++) begin
        sum = {1'b0, pointer_i} + (IDW+1)'(k);
        if (sum >= N_W) sum = sum - N_W;
        if (!found && req_i[sum[IDW-1:0]]) begin
          found                 = 1'b1;
          gnt_o[sum[IDW-1:0]]   = 1'b1;
          gnt_id_o              = sum[IDW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter in front of an 8N1 serializer sharing one UART TX pin.
// req_last=0 locks the grant so a multi-byte packet goes out uninterrupted.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 868,
  parameter int LOCK_TIMEOUT = 4096,
  localparam int IDW = clog2(NUM_REQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);

  localparam int CW = clog2(CLKS_PER_BIT);
  localparam int TW = clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  // Handshake: a byte transfers in any cycle where req_valid[i] and
  // req_ready[i] are both high; ready is only offered in IDLE or HOLD.
  state_e         state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_q, bit_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic [TW-1:0]  to_q, to_d;
  logic           lock_q, lock_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDW-1:0]     arb_id;
  logic [7:0]         data_arr [NUM_REQ];
  logic               bit_end;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[8*g +: 8];
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i     (req_valid),
    .pointer_i (ptr_q),
    .lock_en_i (lock_q),
    .lock_id_i (grant_q),
    .gnt_o     (arb_gnt),
    .gnt_id_o  (arb_id)
  );

  assign bit_end = (cyc_q == CYC_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      to_q    <= '0;
      lock_q  <= 1'b0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      to_q    <= to_d;
      lock_q  <= lock_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    cyc_d     = cyc_q;
    to_d      = to_q;
    lock_d    = lock_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    req_ready = '0;
    case (state_q)
      IDLE, HOLD: begin
        req_ready = arb_gnt;
        if (|arb_gnt) begin
          shift_d = data_arr[arb_id];
          grant_d = arb_id;
          lock_d  = ~req_last[arb_id];
          ptr_d   = (arb_id == IDW'(NUM_REQ - 1)) ? '0 : arb_id + 1'b1;
          cyc_d   = '0;
          to_d    = '0;
          state_d = START;
        end else if (state_q == HOLD) begin
          to_d = to_q + 1'b1;
          if (to_d == TO_LAST) begin
            to_d    = '0;
            lock_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      START: begin
        if (bit_end) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cyc_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) state_d = STOP;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cyc_d   = '0;
          to_d    = '0;
          state_d = lock_q ? HOLD : IDLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoded straight from state so an async reset forces the line idle at once.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy     = (state_q != IDLE) | lock_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: drivers per requester, serial decoder scoreboard.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int CPB = 4;
  localparam int TO  = 16;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx;
  logic           busy;
  logic [1:0]     grant_id;

  uart_tx_arbiter #(.NUM_REQ(N), .CLKS_PER_BIT(CPB), .LOCK_TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         viol = 0;
  logic       rx_busy = 1'b0;
  logic [9:0] exp_q[$];
  int         acc_id[$];
  int         acc_cyc[$];

  // clock / reset block
  initial forever #5 clock = ~clock;
  initial forever begin
    @(posedge clock);
    cyc++;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_tx", tx, 1);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic send(input int id, input logic [7:0] b, input logic last);
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    @(posedge clock);
    #1;
    req_valid[id]       = 1'b1;
    req_data[8*id +: 8] = b;
    req_last[id]        = last;
    while (!done && n < 400) begin
      @(negedge clock);
      if (req_ready[id]) done = 1'b1;
      n++;
    end
    chk("send_accept", done, 1);
    @(posedge clock);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic wait_until(input int n);
    do @(negedge clock); while (cyc < n);
  endtask

  task automatic wait_quiet(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((busy || rx_busy || (|req_valid)) && n < 3000);
    chk(tag, {31'b0, busy | rx_busy}, 0);
  endtask

  // Accept log plus one-hot / ready-implies-valid checks.
  initial forever begin
    @(negedge clock);
    if (!reset && (|req_ready)) begin
      chk("ready_onehot", $onehot0(req_ready), 1);
      chk("ready_no_valid", req_ready & ~req_valid, 0);
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) begin
          acc_id.push_back(i);
          acc_cyc.push_back(cyc);
        end
    end
  end

  // Requester contract: a valid not yet accepted must hold its byte.
  initial begin
    logic [N-1:0]   pv;
    logic [N-1:0]   pr;
    logic [8*N-1:0] pd;
    pv = '0;
    pr = '0;
    pd = '0;
    forever begin
      @(negedge clock);
      if (!reset)
        for (int i = 0; i < N; i++)
          if (pv[i] && !pr[i] && (!req_valid[i] || req_data[8*i +: 8] != pd[8*i +: 8]))
            viol++;
      pv = req_valid;
      pr = req_ready;
      pd = req_data;
    end
  end

  // Serial decoder: compares every cycle of each frame against the expected byte.
  initial begin
    int         rx_cnt;
    int         rx_bad;
    int         bitn;
    logic       rx_have;
    logic [9:0] rx_exp;
    logic [9:0] fr;
    logic [7:0] rx_byte;
    logic [1:0] rx_gid;
    rx_cnt = 0; rx_bad = 0; rx_have = 1'b0; rx_exp = '0; rx_byte = '0; rx_gid = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        rx_busy = 1'b0;
      end else begin
        if (!rx_busy && tx == 1'b0) begin
          rx_busy = 1'b1;
          rx_cnt  = 0;
          rx_bad  = 0;
          rx_byte = '0;
          rx_gid  = grant_id;
          rx_have = (exp_q.size() > 0);
          rx_exp  = rx_have ? exp_q[0] : '0;
        end
        if (rx_busy) begin
          fr   = {1'b1, rx_exp[7:0], 1'b0};
          bitn = rx_cnt / CPB;
          if (tx !== fr[bitn]) rx_bad++;
          if ((rx_cnt % CPB) == CPB/2 && bitn >= 1 && bitn <= 8) rx_byte[bitn-1] = tx;
          if (rx_cnt == 10*CPB - 1) begin
            rx_busy = 1'b0;
            chk("rx_expected", rx_have, 1);
            if (rx_have) begin
              void'(exp_q.pop_front());
              chk("rx_byte", rx_byte, rx_exp[7:0]);
              chk("rx_grant", rx_gid, rx_exp[9:8]);
              chk("rx_wave", rx_bad, 0);
            end
          end
          rx_cnt++;
        end
      end
    end
  end

  initial begin
    int ta;
    int ids2[5];
    int ids3[4];
    ids2 = '{0, 1, 2, 3, 0};
    ids3 = '{2, 2, 2, 1};
    ta = 0;
    do_reset();

    // single byte
    acc_id.delete(); acc_cyc.delete();
    exp_q.push_back({2'd0, 8'hA5});
    send(0, 8'hA5, 1'b1);
    if (acc_cyc.size() > 0) ta = acc_cyc[0];
    wait_until(ta + 40);
    chk("t1_busy_stop", busy, 1);
    wait_until(ta + 41);
    chk("t1_busy_idle", busy, 0);
    wait_quiet("t1_quiet");
    chk("t1_ready_pulses", acc_id.size(), 1);

    // contention from reset
    do_reset();
    acc_id.delete(); acc_cyc.delete();
    exp_q.push_back({2'd0, 8'h10});
    exp_q.push_back({2'd1, 8'h11});
    exp_q.push_back({2'd2, 8'h12});
    exp_q.push_back({2'd3, 8'h13});
    exp_q.push_back({2'd0, 8'h50});
    fork
      begin send(0, 8'h10, 1'b1); send(0, 8'h50, 1'b1); end
      send(1, 8'h11, 1'b1);
      send(2, 8'h12, 1'b1);
      send(3, 8'h13, 1'b1);
    join
    wait_quiet("t2_quiet");
    chk("t2_count", acc_id.size(), 5);
    if (acc_id.size() == 5)
      for (int k = 0; k < 5; k++) begin
        chk("t2_order", acc_id[k], ids2[k]);
        if (k > 0) chk("t2_gap", acc_cyc[k] - acc_cyc[k-1], 41);
      end

    // packet lock
    acc_id.delete(); acc_cyc.delete();
    exp_q.push_back({2'd2, 8'h11});
    exp_q.push_back({2'd2, 8'h22});
    exp_q.push_back({2'd2, 8'h33});
    exp_q.push_back({2'd1, 8'h44});
    fork
      begin send(2, 8'h11, 1'b0); send(2, 8'h22, 1'b0); send(2, 8'h33, 1'b1); end
      begin repeat (3) @(posedge clock); send(1, 8'h44, 1'b1); end
    join
    wait_quiet("t3_quiet");
    chk("t3_count", acc_id.size(), 4);
    if (acc_id.size() == 4)
      for (int k = 0; k < 4; k++) begin
        chk("t3_order", acc_id[k], ids3[k]);
        if (k > 0) chk("t3_gap", acc_cyc[k] - acc_cyc[k-1], 41);
      end

    // lock timeout
    acc_id.delete(); acc_cyc.delete();
    exp_q.push_back({2'd3, 8'h7E});
    exp_q.push_back({2'd0, 8'h5A});
    send(3, 8'h7E, 1'b0);
    if (acc_cyc.size() > 0) ta = acc_cyc[0];
    wait_until(ta + 45);
    chk("t4_hold_busy", busy, 1);
    chk("t4_hold_tx", tx, 1);
    chk("t4_hold_gid", grant_id, 3);
    send(0, 8'h5A, 1'b1);
    wait_quiet("t4_quiet");
    chk("t4_count", acc_id.size(), 2);
    if (acc_id.size() == 2) begin
      chk("t4_id", acc_id[1], 0);
      chk("t4_gap", acc_cyc[1] - acc_cyc[0], 10*CPB + TO + 1);
    end

    // reset mid-frame during data bit 4
    acc_id.delete(); acc_cyc.delete();
    exp_q.push_back({2'd0, 8'hFF});
    send(0, 8'hFF, 1'b1);
    if (acc_cyc.size() > 0) ta = acc_cyc[0];
    wait_until(ta + 22);
    reset = 1'b1;
    #1;
    chk("t5_tx", tx, 1);
    chk("t5_ready", req_ready, 0);
    chk("t5_busy", busy, 0);
    chk("t5_gid", grant_id, 0);
    void'(exp_q.pop_front());
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    exp_q.push_back({2'd0, 8'hC3});
    exp_q.push_back({2'd2, 8'h3C});
    fork
      send(0, 8'hC3, 1'b1);
      send(2, 8'h3C, 1'b1);
    join
    wait_quiet("t5_quiet");
    chk("t5_count", acc_id.size(), 3);
    if (acc_id.size() == 3) begin
      chk("t5_first", acc_id[1], 0);
      chk("t5_second", acc_id[2], 2);
    end

    // held valid while another frame is in flight
    acc_id.delete(); acc_cyc.delete();
    exp_q.push_back({2'd3, 8'h81});
    exp_q.push_back({2'd1, 8'h96});
    send(3, 8'h81, 1'b1);
    send(1, 8'h96, 1'b1);
    wait_quiet("t6_quiet");
    chk("t6_count", acc_id.size(), 2);
    if (acc_id.size() == 2) begin
      chk("t6_id", acc_id[1], 1);
      chk("t6_gap", acc_cyc[1] - acc_cyc[0], 41);
    end

    chk("exp_q_empty", exp_q.size(), 0);
    chk("contract", viol, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
